// File: rtl/imm_encoder_pkg.sv
// -----------------------------------------------------------------------------
// imm_encoder_pkg
// Shared types and constants for the RV32I instruction encoder and any
// block that decodes immediates (the immediate generator uses the same
// imm_src encoding, so its case labels come from imm_src_e below).
//
// Contents:
//   imm_src_e  - immediate format select (I / S / B); other codes are illegal
//   NOP_INSTR  - canonical RV32I NOP (addi x0, x0, 0)
//   enc_req_t  - one encode request as presented on the input side
//   s1_data_t  - what stage 1 keeps: range-check result plus the fields
//                the packer actually needs (only imm[12:0] survives)
// -----------------------------------------------------------------------------
package imm_encoder_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010
  } imm_src_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // imm_src is kept as raw bits so illegal codes 011..111 travel intact
  typedef struct packed {
    logic [2:0]  imm_src;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } enc_req_t;

  // imm[31:13] is fully consumed by the range check, so it is not stored
  typedef struct packed {
    logic        ok;
    logic [2:0]  imm_src;
    logic [12:0] imm;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } s1_data_t;

endpackage

// File: rtl/imm_range_check.sv
// -----------------------------------------------------------------------------
// imm_range_check
// Combinational legality check of a 32-bit signed immediate against the
// field width of the selected RV32I format.
//
// Ports:
//   imm      in  32  full-width signed immediate (byte offset for B)
//   imm_src  in   3  format select (imm_src_e encoding)
//   ok       out  1  immediate is representable in the selected format
//
// I/S hold a 12-bit signed value, so imm[31:11] must be a pure sign
// extension. B holds a 13-bit signed, even byte offset.
// -----------------------------------------------------------------------------
module imm_range_check
  import imm_encoder_pkg::*;
(
  input  logic [31:0] imm,
  input  logic [2:0]  imm_src,
  output logic        ok
);

  logic fits_12;
  logic fits_13;

  assign fits_12 = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign fits_13 = (imm[31:12] == '0) || (imm[31:12] == '1);

  always_comb begin
    ok = 1'b0;
    case (imm_src)
      IMM_I, IMM_S: ok = fits_12;
      IMM_B:        ok = fits_13 && !imm[0];
      default:      ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// -----------------------------------------------------------------------------
// imm_encoder
// Two-stage valid/ready pipeline that packs an immediate plus register and
// opcode fields into a 32-bit RV32I instruction word (I, S or B format).
// Illegal requests (out-of-range immediate or unknown format) are delivered
// in order as the canonical NOP with err set.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   in_valid/in_ready, imm_src, imm, opcode, rd, funct3, rs1, rs2
//                  request side
//   out_valid/out_ready, instr, err
//                  encoded word side; err qualifies instr
//   enc_count      legal words delivered (saturating)
//   err_count      illegal words delivered (saturating)
//
// Handshake: a transfer happens on a side when valid && ready at a rising
// edge. Stage 2 advances when it is empty or downstream is ready; stage 1
// advances when it is empty or stage 2 advances; in_ready is stage 1's
// advance condition (a combinational path from out_ready). While
// out_valid && !out_ready the output word is held unchanged.
// -----------------------------------------------------------------------------
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       imm_src,
  input  logic [31:0]      imm,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [2:0]       funct3,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  enc_req_t    req;
  logic        req_ok;
  s1_data_t    s1_next;
  s1_data_t    s1;
  logic        s1_valid;
  logic        s2_valid;
  logic        s1_adv;
  logic        s2_adv;
  logic [31:0] pack_word;

  always_comb begin
    req.imm_src = imm_src;
    req.imm     = imm;
    req.opcode  = opcode;
    req.rd      = rd;
    req.funct3  = funct3;
    req.rs1     = rs1;
    req.rs2     = rs2;
  end

  imm_range_check u_range (
    .imm     (req.imm),
    .imm_src (req.imm_src),
    .ok      (req_ok)
  );

  always_comb begin
    s1_next.ok      = req_ok;
    s1_next.imm_src = req.imm_src;
    s1_next.imm     = req.imm[12:0];
    s1_next.opcode  = req.opcode;
    s1_next.rd      = req.rd;
    s1_next.funct3  = req.funct3;
    s1_next.rs1     = req.rs1;
    s1_next.rs2     = req.rs2;
  end

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Stage 1: range check result and fields
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
    end
  end

  // Payload needs no reset; it is only observed through s1_valid
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1 <= s1_next;
    end
  end

  // Stage 2 packing
  always_comb begin
    pack_word = NOP_INSTR;
    if (s1.ok) begin
      case (s1.imm_src)
        IMM_I: pack_word = {s1.imm[11:0], s1.rs1, s1.funct3, s1.rd, s1.opcode};
        IMM_S: pack_word = {s1.imm[11:5], s1.rs2, s1.rs1, s1.funct3,
                            s1.imm[4:0], s1.opcode};
        IMM_B: pack_word = {s1.imm[12], s1.imm[10:5], s1.rs2, s1.rs1, s1.funct3,
                            s1.imm[4:1], s1.imm[11], s1.opcode};
        default: pack_word = NOP_INSTR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      instr    <= '0;
      err      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        instr <= pack_word;
        err   <= !s1.ok;
      end
    end
  end

  // Delivered-word counters, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (out_valid && out_ready) begin
      if (!err) begin
        if (enc_count != '1) enc_count <= enc_count + 1'b1;
      end else begin
        if (err_count != '1) err_count <= err_count + 1'b1;
      end
    end
  end

endmodule
